ahb_mem_bridge: RTL and testbench



---
 rtl/ahb_mem_bridge.sv | 171 +++++++++++++++++
 tb/tb_ahb_mem_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_mem_bridge.sv
// AHB-Lite slave that turns bus transfers into single-port memory requests.
// Registered request (MEN/MADDR/MWE) in the first data-phase cycle, memory
// wait states stretch the data phase, and every failure produces the
// two-cycle AHB ERROR response.
module ahb_mem_bridge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned MEM_BYTES  = 1048576,
  parameter int unsigned MAX_WAIT   = 16,
  localparam int unsigned DATA_BYTES = DATA_WIDTH / 8,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_BYTES) + 1,
  localparam int unsigned OFS        = $clog2(DATA_BYTES)
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic                  HREADYIN,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  MEN,
  output logic [DATA_BYTES-1:0] MWE,
  output logic [ADDR_WIDTH-1:0] MADDR,
  output logic [DATA_WIDTH-1:0] MDIN,
  input  logic                  MREADY,
  input  logic                  MERROR,
  input  logic [DATA_WIDTH-1:0] MDOUT,
  output logic [15:0]           ERRCNT
);

  localparam int unsigned WCNT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   maddr_q;
  logic [DATA_BYTES-1:0]   mwe_q;
  logic                    write_q;
  logic [WCNT_W-1:0]       wait_q;
  logic [15:0]             errcnt_q;

  logic                    accept;
  logic                    range_ok, size_ok, align_ok, check_ok;
  logic                    timeout_hit;
  logic                    load;
  logic [ADDR_WIDTH-1:0]   align_mask;
  logic [ADDR_WIDTH-1:0]   rel_addr;
  logic [DATA_BYTES-1:0]   lanes;
  logic [63:0]             addr_ext;
  logic                    in_access;

  // Control signals that only matter for other slaves' timing are ignored.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

  assign accept    = HSEL & HTRANS[1] & HREADYIN;
  assign in_access = (state_q == S_ACCESS);

  // Address-phase checks: decode window, transfer size and natural alignment.
  assign addr_ext   = 64'(HADDR);
  assign range_ok   = (addr_ext >= 64'(ADDR_BASE)) &&
                      (addr_ext <= 64'(ADDR_BASE) + 64'(MEM_BYTES) - 64'd1);
  assign size_ok    = ({29'd0, HSIZE} <= OFS);
  assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
  assign align_ok   = ((HADDR & align_mask) == '0);
  assign check_ok   = range_ok & size_ok & align_ok;

  // Memory address is relative to the slave base, forced to a full data word.
  assign rel_addr = (HADDR - ADDR_WIDTH'(ADDR_BASE)) & ~ADDR_WIDTH'(DATA_BYTES - 1);

  // Byte lanes covered by an aligned transfer of 2^HSIZE bytes.
  always_comb begin
    lanes = '0;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      lanes[i] = ((i >> HSIZE) == (32'(HADDR[OFS-1:0]) >> HSIZE));
    end
  end

  // The last permitted wait cycle is the one where the counter shows MAX_WAIT-1.
  assign timeout_hit = (MAX_WAIT != 0) && !MREADY &&
                       (wait_q == WCNT_W'(MAX_WAIT - 1));

  // Next-state and handshake decode.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    load      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_IDLE;
      S_ACCESS: begin
        HREADYOUT = MREADY & ~MERROR;
        if (MREADY && !MERROR)     state_d = S_IDLE;
        else if (MREADY && MERROR) state_d = S_ERR1;
        else if (timeout_hit)      state_d = S_ERR1;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        HRESP   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // A new address phase is only taken when the current data phase ends.
    if (HREADYOUT && accept) begin
      state_d = check_ok ? S_ACCESS : S_ERR1;
      load    = check_ok;
    end
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request registers: captured at accept, held stable for the whole access.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      maddr_q <= '0;
      mwe_q   <= '0;
      write_q <= 1'b0;
    end else if (load) begin
      maddr_q <= rel_addr;
      mwe_q   <= HWRITE ? lanes : '0;
      write_q <= HWRITE;
    end
  end

  // Wait counter: restarts with each access, counts stalled ACCESS cycles.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                      wait_q <= '0;
    else if (load)                                   wait_q <= '0;
    else if (in_access && !MREADY && wait_q != '1)   wait_q <= wait_q + WCNT_W'(1);
  end

  // Saturating count of completed ERROR responses.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)                                         errcnt_q <= '0;
    else if (state_q == S_ERR2 && errcnt_q != 16'hFFFF) errcnt_q <= errcnt_q + 16'd1;
  end

  assign MEN    = in_access;
  assign MADDR  = maddr_q;
  assign MWE    = in_access ? mwe_q : '0;
  assign MDIN   = (in_access && write_q)  ? HWDATA : '0;
  assign HRDATA = (in_access && !write_q) ? MDOUT  : '0;
  assign ERRCNT = errcnt_q;

endmodule

// File: tb/tb_ahb_mem_bridge.sv
// Directed self-checking bench for ahb_mem_bridge with default parameters
// (32-bit data, base 0, 1 MiB, MAX_WAIT=16) and a small byte-lane memory model.
module tb_ahb_mem_bridge;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel, hwrite, hmastlock;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [20:0] haddr;
  logic [31:0] hwdata, hrdata;
  logic        hreadyout, hresp;
  logic        men;
  logic [3:0]  mwe;
  logic [20:0] maddr;
  logic [31:0] mdin, mdout;
  logic        mready, merror;
  logic [15:0] errcnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [256];

  always #5 hclk = ~hclk;

  ahb_mem_bridge dut (
    .HCLK(hclk), .HRESET(hreset), .HSEL(hsel), .HREADYIN(hreadyout),
    .HWRITE(hwrite), .HTRANS(htrans), .HSIZE(hsize), .HBURST(hburst),
    .HPROT(hprot), .HMASTLOCK(hmastlock), .HADDR(haddr), .HWDATA(hwdata),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp), .MEN(men),
    .MWE(mwe), .MADDR(maddr), .MDIN(mdin), .MREADY(mready), .MERROR(merror),
    .MDOUT(mdout), .ERRCNT(errcnt)
  );

  // Memory model: byte-lane writes on a good completion, combinational read.
  always @(posedge hclk) begin
    if (men && mready && !merror)
      for (int b = 0; b < 4; b++)
        if (mwe[b]) mem[maddr[9:2]][b*8 +: 8] <= mdin[b*8 +: 8];
  end
  assign mdout = mem[maddr[9:2]];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One non-pipelined transfer; called and returns at posedge+1.
  // waits: data-phase cycles with MREADY low; merr: MERROR on completion.
  task automatic xfer(input logic wr, input logic [20:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, input int waits, input logic merr,
                      output int cycles, output logic [31:0] rdata,
                      output logic resp_first, output logic resp_last,
                      output logic men_seen, output logic [3:0] mwe_first,
                      output logic [20:0] maddr_first, output logic [31:0] mdin_first,
                      output logic maddr_stable);
    logic rdy;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    cycles = 0; men_seen = 1'b0; maddr_stable = 1'b1; rdy = 1'b0;
    resp_first = 1'b0; resp_last = 1'b0; rdata = '0;
    mwe_first = '0; maddr_first = '0; mdin_first = '0;
    while (!rdy && cycles < 100) begin
      mready = (cycles >= waits);
      merror = merr && (cycles >= waits);
      @(negedge hclk);
      if (cycles == 0) begin
        resp_first = hresp; mwe_first = mwe; maddr_first = maddr; mdin_first = mdin;
      end else if (men && maddr != maddr_first) begin
        maddr_stable = 1'b0;
      end
      men_seen |= men;
      rdy       = hreadyout;
      resp_last = hresp;
      rdata     = hrdata;
      cycles++;
      @(posedge hclk); #1;
    end
    mready = 1'b1; merror = 1'b0;
  endtask

  int          cyc;
  logic [31:0] rd;
  logic        rf, rl, ms, stable;
  logic [3:0]  mw;
  logic [20:0] ma;
  logic [31:0] md;
  int          ready_cnt;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hreset = 1'b1; hsel = 0; hwrite = 0; htrans = 0; hsize = 0; hburst = 0;
    hprot = 0; hmastlock = 0; haddr = 0; hwdata = 0; mready = 1; merror = 0;
    #12;
    check("rst_hreadyout", hreadyout, 1);
    check("rst_hresp",     hresp,     0);
    check("rst_men",       men,       0);
    check("rst_mwe",       mwe,       0);
    check("rst_maddr",     maddr,     0);
    check("rst_mdin",      mdin,      0);
    check("rst_hrdata",    hrdata,    0);
    check("rst_errcnt",    errcnt,    0);
    @(posedge hclk); #1; hreset = 1'b0;

    // Word write then read back.
    xfer(1, 21'h10, 3'd2, 32'hDEADBEEF, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("wr_cycles", cyc, 1);
    check("wr_resp",   rl,  0);
    check("wr_mwe",    mw,  4'hF);
    check("wr_maddr",  ma,  21'h10);
    check("wr_mdin",   md,  32'hDEADBEEF);
    xfer(0, 21'h10, 3'd2, 32'h0, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("rd_cycles", cyc, 1);
    check("rd_resp",   rl,  0);
    check("rd_mwe",    mw,  4'h0);
    check("rd_data",   rd,  32'hDEADBEEF);

    // Byte and halfword lanes.
    xfer(1, 21'h13, 3'd0, 32'hAA000000, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("byte_mwe",   mw, 4'b1000);
    check("byte_maddr", ma, 21'h10);
    xfer(0, 21'h10, 3'd2, 32'h0, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("byte_rd", rd, 32'hAAADBEEF);
    xfer(1, 21'h12, 3'd1, 32'h12340000, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("half_mwe", mw, 4'b1100);

    // Misaligned halfword: ERROR pair, no memory request.
    xfer(1, 21'h11, 3'd1, 32'h0, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("misal_cycles", cyc, 2);
    check("misal_resp1",  rf,  1);
    check("misal_resp2",  rl,  1);
    check("misal_men",    ms,  0);
    check("misal_errcnt", errcnt, 1);

    // Oversized transfer for a 32-bit bus.
    xfer(0, 21'h18, 3'd3, 32'h0, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("size_cycles", cyc, 2);
    check("size_men",    ms,  0);
    check("size_errcnt", errcnt, 2);

    // Three memory wait states on a read.
    xfer(0, 21'h10, 3'd2, 32'h0, 3, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("wait_cycles", cyc,    4);
    check("wait_stable", stable, 1);
    check("wait_resp",   rl,     0);
    check("wait_data",   rd,     32'h1234BEEF);

    // Stalled memory: 16 wait cycles, then ERR1/ERR2.
    xfer(0, 21'h40, 3'd2, 32'h0, 1000, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("tmo_cycles", cyc, 18);
    check("tmo_menseen", ms, 1);
    check("tmo_resp",   rl,  1);
    check("tmo_men",    men, 0);
    check("tmo_errcnt", errcnt, 3);

    // One past the top of the window.
    xfer(0, 21'h100000, 3'd2, 32'h0, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("oor_cycles", cyc, 2);
    check("oor_men",    ms,  0);
    check("oor_errcnt", errcnt, 4);

    // Memory error on a write: ACCESS(not ready) + ERR1 + ERR2.
    xfer(1, 21'h30, 3'd2, 32'h55555555, 0, 1, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("merr_cycles", cyc, 3);
    check("merr_resp1",  rf,  0);
    check("merr_resp",   rl,  1);
    check("merr_errcnt", errcnt, 5);

    // Four back-to-back pipelined reads.
    for (int i = 0; i < 4; i++)
      xfer(1, 21'h20 + 21'(4*i), 3'd2, 32'hC0DE0000 + 32'(i), 0, 0,
           cyc, rd, rf, rl, ms, mw, ma, md, stable);
    ready_cnt = 0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        hsel = 1; htrans = 2'b10; hwrite = 0; hsize = 3'd2; haddr = 21'h20 + 21'(4*i);
      end else begin
        hsel = 0; htrans = 2'b00;
      end
      if (i > 0) begin
        @(negedge hclk);
        if (hreadyout) ready_cnt++;
        check($sformatf("b2b_data%0d", i-1), hrdata, 32'hC0DE0000 + 32'(i-1));
      end
      @(posedge hclk); #1;
    end
    check("b2b_ready", ready_cnt, 4);

    // Reset in the middle of a stalled access.
    hsel = 1; htrans = 2'b10; hwrite = 0; hsize = 3'd2; haddr = 21'h10;
    @(posedge hclk); #1;
    hsel = 0; htrans = 2'b00; mready = 0;
    @(negedge hclk);
    check("mid_men",    men,       1);
    check("mid_hready", hreadyout, 0);
    #1 hreset = 1'b1;
    #1;
    check("rst_mid_men",    men,       0);
    check("rst_mid_hready", hreadyout, 1);
    check("rst_mid_hresp",  hresp,     0);
    check("rst_mid_errcnt", errcnt,    0);
    @(posedge hclk); #1; hreset = 1'b0; mready = 1;
    xfer(0, 21'h10, 3'd2, 32'h0, 0, 0, cyc, rd, rf, rl, ms, mw, ma, md, stable);
    check("post_cycles", cyc, 1);
    check("post_data",   rd,  32'h1234BEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
